// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction-fetch and LSU masters.
// An in-order ID FIFO routes each response back to the master that issued the request.
module mem_port_arbiter #(
  parameter int WORD_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8,
  parameter int DATA_PRIORITY   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [WORD_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [WORD_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [WORD_WIDTH-1:0] data_rdata_o,
  output logic                  mem_req_o,
  output logic [WORD_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;
  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        state, state_nxt;
  logic [(1<<PW)-1:0] id_fifo;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;
  logic              last_winner;
  logic              sel_vld, sel;
  logic              full, empty, push, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);
  assign head  = id_fifo[rd_ptr];

  always_comb begin
    sel_vld   = 1'b0;
    sel       = ID_D;
    state_nxt = IDLE;
    case (state)
      LOCK_I: begin sel = ID_I; sel_vld = instr_req_i; end
      LOCK_D: begin sel = ID_D; sel_vld = data_req_i; end
      default: begin
        sel_vld = !full && (instr_req_i || data_req_i);
        if (instr_req_i && data_req_i) begin
          if (DATA_PRIORITY != 0)
            sel = (starve_cnt == SW'(STARVE_LIMIT)) ? ID_I : ID_D;
          else
            sel = ~last_winner;
        end else begin
          sel = data_req_i ? ID_D : ID_I;
        end
      end
    endcase
    // Outputs must read zero while reset is held, even with a master requesting.
    sel_vld = sel_vld & rst_n;
    if (sel_vld && !mem_gnt_i)
      state_nxt = sel ? LOCK_D : LOCK_I;
  end

  assign mem_req_o   = sel_vld;
  assign mem_addr_o  = !sel_vld ? '0 : (sel ? data_addr_i : instr_addr_i);
  assign mem_we_o    = sel_vld & sel & data_we_i;
  assign mem_be_o    = !sel_vld ? 4'h0 : (sel ? data_be_i : 4'hF);
  assign mem_wdata_o = (sel_vld && sel) ? data_wdata_i : '0;

  assign push        = sel_vld & mem_gnt_i;
  assign instr_gnt_o = push & ~sel;
  assign data_gnt_o  = push & sel;

  assign pop            = mem_rvalid_i & ~empty;
  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign busy_o = (state != IDLE) || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      id_fifo     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      last_winner <= ID_D;
    end else begin
      state <= state_nxt;
      if (push) begin
        id_fifo[wr_ptr] <= sel;
        wr_ptr          <= ptr_inc(wr_ptr);
        last_winner     <= sel;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (!instr_req_i || instr_gnt_o)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, hand-written corner sequences and
// randomized traffic against a queue-based reference model, on both priority modes.
module tb_mem_port_arbiter;
  localparam int MAXO = 2;
  localparam int LIM  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ireq, dreq, dwe, mgnt, mrv;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dbe;

  // index 1: DATA_PRIORITY=1, index 0: DATA_PRIORITY=0
  logic        ignt[2], irv[2], dgnt[2], drv[2], mreq[2], mwe[2], busy[2];
  logic [31:0] irdata[2], drdata[2], maddr[2], mwdata[2];
  logic [3:0]  mbe[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_WIDTH(32), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM), .DATA_PRIORITY(1)) u_dp1 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(ignt[1]),
    .instr_rvalid_o(irv[1]), .instr_rdata_o(irdata[1]),
    .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
    .data_wdata_i(dwdata), .data_gnt_o(dgnt[1]), .data_rvalid_o(drv[1]), .data_rdata_o(drdata[1]),
    .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]), .mem_we_o(mwe[1]), .mem_be_o(mbe[1]),
    .mem_wdata_o(mwdata[1]), .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
    .busy_o(busy[1]));

  mem_port_arbiter #(.WORD_WIDTH(32), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM), .DATA_PRIORITY(0)) u_dp0 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(ignt[0]),
    .instr_rvalid_o(irv[0]), .instr_rdata_o(irdata[0]),
    .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
    .data_wdata_i(dwdata), .data_gnt_o(dgnt[0]), .data_rvalid_o(drv[0]), .data_rdata_o(drdata[0]),
    .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]), .mem_we_o(mwe[0]), .mem_be_o(mbe[0]),
    .mem_wdata_o(mwdata[0]), .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
    .busy_o(busy[0]));

  typedef struct {
    logic ir, dr, g, rv;
    logic mr; logic [31:0] ma; logic we, ig, dg, irv, drv, bsy;
  } vec_t;

  vec_t tbl [12];

  // reference model state, per instance
  int lock [2];   // 0 none, 1 locked on instr, 2 locked on data
  int q [2][$];   // IDs of granted, unanswered transactions (0 instr, 1 data)
  int starve [2];
  int last [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ir, input logic dr, input logic g, input logic rv);
    ireq = ir; dreq = dr; mgnt = g; mrv = rv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    mrdata = '0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset mreq%0d", k), 32'(mreq[k]), 0);
      chk($sformatf("reset busy%0d", k), 32'(busy[k]), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lock[k] = 0; q[k].delete(); starve[k] = 0; last[k] = 1;
    end
  endtask

  task automatic model_cycle(input int k);
    int cand;
    int hd;
    logic gnt_e, irv_e, drv_e;
    if (lock[k] == 1)           cand = ireq ? 0 : -1;
    else if (lock[k] == 2)      cand = dreq ? 1 : -1;
    else if (q[k].size() >= MAXO) cand = -1;
    else if (ireq && dreq)      cand = (k == 1) ? ((starve[k] == LIM) ? 0 : 1) : ((last[k] == 1) ? 0 : 1);
    else                        cand = ireq ? 0 : (dreq ? 1 : -1);
    gnt_e = (cand >= 0) && mgnt;
    hd = (q[k].size() > 0) ? q[k][0] : -1;
    irv_e = mrv && hd == 0;
    drv_e = mrv && hd == 1;
    chk($sformatf("rnd%0d mreq", k), 32'(mreq[k]), 32'(cand >= 0));
    chk($sformatf("rnd%0d maddr", k), maddr[k], (cand < 0) ? 0 : (cand == 1 ? daddr : iaddr));
    chk($sformatf("rnd%0d mwe", k), 32'(mwe[k]), 32'(cand == 1 && dwe));
    chk($sformatf("rnd%0d mbe", k), 32'(mbe[k]), (cand < 0) ? 0 : (cand == 1 ? 32'(dbe) : 32'hF));
    chk($sformatf("rnd%0d mwdata", k), mwdata[k], (cand == 1) ? dwdata : 0);
    chk($sformatf("rnd%0d ignt", k), 32'(ignt[k]), 32'(gnt_e && cand == 0));
    chk($sformatf("rnd%0d dgnt", k), 32'(dgnt[k]), 32'(gnt_e && cand == 1));
    chk($sformatf("rnd%0d irv", k), 32'(irv[k]), 32'(irv_e));
    chk($sformatf("rnd%0d drv", k), 32'(drv[k]), 32'(drv_e));
    chk($sformatf("rnd%0d busy", k), 32'(busy[k]), 32'(lock[k] != 0 || q[k].size() > 0));
    chk($sformatf("rnd%0d rdata", k), irdata[k] ^ drdata[k] ^ mrdata, mrdata);
    if (hd >= 0 && mrv) void'(q[k].pop_front());
    if (gnt_e) begin q[k].push_back(cand); last[k] = cand; end
    lock[k] = (cand >= 0 && !mgnt) ? cand + 1 : 0;
    starve[k] = (ireq && !(gnt_e && cand == 0)) ? ((starve[k] < LIM) ? starve[k] + 1 : LIM) : 0;
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    iaddr = 32'h200; daddr = 32'h100; dwe = 1'b1; dbe = 4'h3; dwdata = 32'hDEAD; mrdata = '0;
    //          ir dr g rv  mr ma       we ig dg irv drv bsy
    tbl[0]  = '{0, 1, 0, 0, 1, 32'h100, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 32'h100, 1, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 0, 1, 32'h100, 1, 0, 0, 0, 0, 1};
    tbl[3]  = '{1, 1, 1, 0, 1, 32'h100, 1, 0, 1, 0, 0, 1};
    tbl[4]  = '{1, 0, 1, 0, 1, 32'h200, 0, 1, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 1, 1, 0, 32'h0,   0, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 0, 1, 1, 1, 32'h200, 0, 1, 0, 1, 0, 1};
    tbl[7]  = '{0, 0, 0, 1, 0, 32'h0,   0, 0, 0, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 1, 0, 32'h0,   0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 1, 32'h100, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(tbl[i].ir, tbl[i].dr, tbl[i].g, tbl[i].rv);
      mrdata = 32'h1000 + 32'(i);
      #1;
      chk($sformatf("tbl%0d mreq", i), 32'(mreq[1]), 32'(tbl[i].mr));
      chk($sformatf("tbl%0d maddr", i), maddr[1], tbl[i].ma);
      chk($sformatf("tbl%0d mwe", i), 32'(mwe[1]), 32'(tbl[i].we));
      chk($sformatf("tbl%0d ignt", i), 32'(ignt[1]), 32'(tbl[i].ig));
      chk($sformatf("tbl%0d dgnt", i), 32'(dgnt[1]), 32'(tbl[i].dg));
      chk($sformatf("tbl%0d irv", i), 32'(irv[1]), 32'(tbl[i].irv));
      chk($sformatf("tbl%0d drv", i), 32'(drv[1]), 32'(tbl[i].drv));
      chk($sformatf("tbl%0d busy", i), 32'(busy[1]), 32'(tbl[i].bsy));
      if (tbl[i].irv) chk($sformatf("tbl%0d irdata", i), irdata[1], 32'h1000 + 32'(i));
      if (tbl[i].drv) chk($sformatf("tbl%0d drdata", i), drdata[1], 32'h1000 + 32'(i));
    end

    // starvation guard: eight data grants, then instr, then data again
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      set_in(1, 1, 1, 1);
      #1;
      chk($sformatf("starve c%0d dgnt", c), 32'(dgnt[1]), 32'(c != 8));
      chk($sformatf("starve c%0d ignt", c), 32'(ignt[1]), 32'(c == 8));
    end

    // reset while locked on data with one instr transaction outstanding
    do_reset();
    @(negedge clk); set_in(1, 0, 1, 0); #1;
    chk("rst5 ignt", 32'(ignt[1]), 1);
    @(negedge clk); set_in(0, 1, 0, 0); #1;
    chk("rst5 lock mreq", 32'(mreq[1]), 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst5 mreq", 32'(mreq[1]), 0);
    chk("rst5 maddr", maddr[1], 0);
    chk("rst5 mbe", 32'(mbe[1]), 0);
    chk("rst5 dgnt", 32'(dgnt[1]), 0);
    chk("rst5 busy", 32'(busy[1]), 0);
    @(negedge clk); rst_n = 1'b1; set_in(0, 0, 0, 1); #1;
    chk("rst5 irv", 32'(irv[1]), 0);
    chk("rst5 drv", 32'(drv[1]), 0);

    // round-robin: one lone instr grant, then ties alternate D,I,D,I
    do_reset();
    @(negedge clk); set_in(1, 0, 1, 1); #1;
    chk("rr ignt0", 32'(ignt[0]), 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); set_in(1, 1, 1, 1); #1;
      chk($sformatf("rr c%0d dgnt", c), 32'(dgnt[0]), 32'(c % 2 == 0));
      chk($sformatf("rr c%0d ignt", c), 32'(ignt[0]), 32'(c % 2 == 1));
      if (c % 2 == 1) begin
        chk($sformatf("rr c%0d mbe", c), 32'(mbe[0]), 32'hF);
        chk($sformatf("rr c%0d mwe", c), 32'(mwe[0]), 0);
      end
    end

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
      iaddr = $urandom; daddr = $urandom; dwdata = $urandom; mrdata = $urandom;
      dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom_range(0, 15));
      #1;
      model_cycle(1);
      model_cycle(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
